// File: rtl/natreorder_pp.sv
// natreorder_pp: ping-pong bit-reversal reorder buffer.
// Samples arrive in bit-reversed order within each frame of N = 2^K words.
// Each sample is written at its bit-reversed address. The frame is then read
// back linearly, so it leaves in natural order. Two banks alternate: one bank
// fills while the other drains.
module natreorder_pp #(
  parameter int K  = 10,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  input  logic          last_i,
  output logic          ready_o,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic          last_o,
  input  logic          ready_i,
  output logic          err_o
);

  localparam int N = 1 << K;
  localparam logic [K-1:0] LAST_IDX = '1;

  typedef enum logic {
    BANK_FREE = 1'b0,
    BANK_FULL = 1'b1
  } bank_st_e;

  // Bank occupancy, write/read pointers and counters.
  bank_st_e       r_bank_st [2];
  logic           r_wsel;
  logic           r_rsel;
  logic [K-1:0]   r_wcnt;
  logic [K-1:0]   r_rcnt;
  logic           r_err;

  // Storage: one array per bank, so each bank maps onto its own
  // simple dual-port memory (one write port, one asynchronous read port).
  logic [DW-1:0]  r_mem0 [N];
  logic [DW-1:0]  r_mem1 [N];

  logic           w_wr_fire;
  logic           w_rd_fire;
  logic           w_wr_wrap;
  logic           w_rd_wrap;
  logic           w_wr_at_end;
  logic [K-1:0]   w_waddr;
  logic [DW-1:0]  w_rd_data;

  // Mirror the K-bit index: bit i of the result is bit K-1-i of the input.
  function automatic logic [K-1:0] bitrev(input logic [K-1:0] v);
    logic [K-1:0] r;
    for (int i = 0; i < K; i++) begin
      r[i] = v[K-1-i];
    end
    return r;
  endfunction

  // Handshakes. ready_o depends only on bank state and never on valid_i.
  // It is high during reset because both banks reset to FREE.
  assign ready_o     = (r_bank_st[r_wsel] == BANK_FREE);
  assign valid_o     = (r_bank_st[r_rsel] == BANK_FULL);
  assign w_wr_fire   = valid_i && ready_o;
  assign w_rd_fire   = valid_o && ready_i;
  assign w_wr_at_end = (r_wcnt == LAST_IDX);
  assign w_wr_wrap   = w_wr_fire && w_wr_at_end;
  assign w_rd_wrap   = w_rd_fire && (r_rcnt == LAST_IDX);
  assign w_waddr     = bitrev(r_wcnt);

  // Bank state. Filling sets a bank FULL and draining sets one FREE.
  // The write bank is always FREE and the read bank is always FULL, so the
  // two banks involved are never the same bank. Both updates can therefore
  // land on the same edge without conflict.
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples pre-edge values, independent of the order of the statements.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_bank_st[0] <= BANK_FREE;
      r_bank_st[1] <= BANK_FREE;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_wr_wrap && (r_wsel == 1'(b))) begin
          r_bank_st[b] <= BANK_FULL;
        end else if (w_rd_wrap && (r_rsel == 1'(b))) begin
          r_bank_st[b] <= BANK_FREE;
        end
      end
    end
  end

  // Write side: count accepted samples and switch banks on the frame's
  // last sample. Framing follows this counter alone, never last_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wcnt <= '0;
      r_wsel <= 1'b0;
    end else if (w_wr_fire) begin
      r_wcnt <= r_wcnt + 1'b1;
      if (w_wr_at_end) begin
        r_wsel <= ~r_wsel;
      end
    end
  end

  // Read side: walk the addresses linearly and hand the bank back after the
  // frame's last output transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rcnt <= '0;
      r_rsel <= 1'b0;
    end else if (w_rd_fire) begin
      r_rcnt <= r_rcnt + 1'b1;
      if (r_rcnt == LAST_IDX) begin
        r_rsel <= ~r_rsel;
      end
    end
  end

  // Framing check: flag an accepted sample whose last_i disagrees with the
  // write counter's view of the end of the frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_wr_fire && (last_i != w_wr_at_end);
    end
  end

  // Sample storage: write each accepted sample at its bit-reversed address.
  // NOTE: the memories have no reset. Their contents only become visible
  // after a complete frame has overwritten every address, so resetting them
  // would cost logic and gain nothing.
  always_ff @(posedge clk_i) begin
    if (w_wr_fire && !r_wsel) begin
      r_mem0[w_waddr] <= data_i;
    end
    if (w_wr_fire && r_wsel) begin
      r_mem1[w_waddr] <= data_i;
    end
  end

  // Combinational read of the draining bank. This gives zero-bubble output.
  // Data stays stable under backpressure because r_rcnt and r_rsel only move
  // on a transfer.
  // NOTE: the output is given a default before the selection. No path can
  // leave it unassigned, so no latch is inferred.
  always_comb begin
    w_rd_data = r_mem0[r_rcnt];
    if (r_rsel) begin
      w_rd_data = r_mem1[r_rcnt];
    end
  end

  assign data_o = w_rd_data;
  assign last_o = valid_o && (r_rcnt == LAST_IDX);
  assign err_o  = r_err;

endmodule

// File: tb/tb_natreorder_pp.sv
// tb_natreorder_pp: scoreboard bench for natreorder_pp (K=4, N=16, DW=32).
// Stimulus tasks drive frames. A negedge monitor records accepted inputs.
// When a frame completes, the monitor derives the natural-order output frame
// from it, pushes that frame into a queue, and compares outputs as they
// appear.
module tb_natreorder_pp;

  localparam int K   = 4;
  localparam int N   = 1 << K;
  localparam int DW  = 32;
  localparam int TMO = 2000;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          valid_i;
  logic [DW-1:0] data_i;
  logic          last_i;
  logic          ready_o;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic          last_o;
  logic          ready_i;
  logic          err_o;

  natreorder_pp #(.K(K), .DW(DW)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .data_i  (data_i),
    .last_i  (last_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .last_o  (last_o),
    .ready_i (ready_i),
    .err_o   (err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Scoreboard and reference state.
  exp_t          exp_q [$];
  logic [DW-1:0] frame_buf [N];
  int            in_cnt     = 0;
  bit            exp_err    = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;

  // Statistics read by the directed tests.
  int cyc           = 0;
  int err_cnt       = 0;
  int ready_low_cnt = 0;
  int out_cnt       = 0;
  int first_done    = -1;
  int first_out     = -1;
  int last_out      = -1;
  int rdy_mode      = 0;   // 0: ready_i low, 1: high, 2: random 50%

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rev_k(input int j);
    int r = 0;
    for (int b = 0; b < K; b++) begin
      if (((j >> b) & 1) != 0) r += 1 << (K - 1 - b);
    end
    return r;
  endfunction

  // Monitor and scoreboard. It runs on the falling edge, away from the
  // active edge.
  always @(negedge clk_i) begin
    exp_t e;
    cyc++;
    if (!rst_ni) begin
      check("rst_valid_o", valid_o, 1'b0);
      check("rst_last_o", last_o, 1'b0);
      check("rst_ready_o", ready_o, 1'b1);
      check("rst_err_o", err_o, 1'b0);
      exp_q.delete();
      in_cnt     = 0;
      exp_err    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      // A bank stays FULL until its last sample leaves. Hence a complete
      // frame is buffered while any expected output is pending. Both banks
      // are occupied once more than one frame's worth is pending.
      check("valid_o", valid_o, exp_q.size() > 0);
      check("ready_o", ready_o, exp_q.size() <= N);
      check("err_o", err_o, exp_err);
      if (err_o) err_cnt++;
      if (!ready_o) ready_low_cnt++;
      if (!valid_o) check("last_o_idle", last_o, 1'b0);
      if (prev_stall) begin
        check("stall_valid_o", valid_o, 1'b1);
        check("stall_data_o", data_o, prev_data);
      end
      prev_stall = valid_o && !ready_i;
      prev_data  = data_o;

      if (valid_o && ready_i) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("data_o", data_o, e.d);
          check("last_o", last_o, e.l);
        end
        out_cnt++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end

      exp_err = 1'b0;
      if (valid_i && ready_o) begin
        exp_err = (last_i != (in_cnt == N - 1));
        frame_buf[in_cnt] = data_i;
        in_cnt++;
        if (in_cnt == N) begin
          // The j-th arrival carries natural index rev_k(j). Output i
          // is therefore the arrival numbered rev_k(i).
          for (int i = 0; i < N; i++) begin
            e.d = frame_buf[rev_k(i)];
            e.l = (i == N - 1);
            exp_q.push_back(e);
          end
          in_cnt = 0;
          if (first_done < 0) first_done = cyc;
        end
      end
    end
  end

  // Downstream ready driver.
  initial begin
    ready_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      case (rdy_mode)
        0:       ready_i = 1'b0;
        1:       ready_i = 1'b1;
        default: ready_i = 1'($urandom_range(1, 0));
      endcase
    end
  end

  // Offer one sample and hold it until accepted. The task is entered and
  // left 1 time unit after a rising edge.
  task automatic send(input logic [DW-1:0] d, input logic l, input bit gap);
    bit acc;
    bit done;
    done = 1'b0;
    if (gap && ($urandom_range(1, 0) == 1)) begin
      valid_i = 1'b0;
      @(posedge clk_i);
      #1;
    end
    valid_i = 1'b1;
    data_i  = d;
    last_i  = l;
    for (int t = 0; t < TMO; t++) begin
      @(negedge clk_i);
      acc = ready_o;
      @(posedge clk_i);
      #1;
      if (acc) begin
        done = 1'b1;
        break;
      end
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
    check("send_timeout", done, 1'b1);
  endtask

  task automatic wait_drain();
    bit empty;
    empty = 1'b0;
    for (int t = 0; t < TMO; t++) begin
      @(negedge clk_i);
      if (exp_q.size() == 0 && !valid_o) begin
        empty = 1'b1;
        break;
      end
    end
    check("drain_timeout", empty, 1'b1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_ready(input int mode);
    rdy_mode = mode;
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  initial begin
    int err0;
    int out0;
    bit seen;
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    last_i  = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Single frame with ready_i low. Natural-order output is 0..15.
    err0 = err_cnt;
    for (int j = 0; j < N; j++) send(DW'(rev_k(j)), j == N - 1, 1'b0);
    @(negedge clk_i);
    check("t1_valid_after_16", valid_o, 1'b1);
    check("t1_first_data", data_o, 32'd0);
    @(posedge clk_i);
    #1;
    set_ready(1);
    wait_drain();
    check("t1_err_pulses", err_cnt - err0, 0);

    // Three back-to-back frames, one sample per cycle.
    first_done = -1;
    first_out  = -1;
    last_out   = -1;
    out0 = out_cnt;
    ready_low_cnt = 0;
    for (int f = 0; f < 3; f++)
      for (int j = 0; j < N; j++) send(DW'(16 * f + rev_k(j)), j == N - 1, 1'b0);
    wait_drain();
    check("t2_out_count", out_cnt - out0, 48);
    check("t2_ready_low", ready_low_cnt, 0);
    check("t2_latency", first_out - first_done, 1);
    check("t2_no_bubbles", last_out - first_out, 47);

    // Backpressure: two frames fill both banks.
    set_ready(0);
    for (int j = 0; j < 2 * N; j++) send(DW'(200 + j), (j % N) == N - 1, 1'b0);
    @(negedge clk_i);
    check("t3_ready_both_full", ready_o, 1'b0);
    @(posedge clk_i);
    #1;
    rdy_mode = 2;
    seen = 1'b0;
    for (int t = 0; t < TMO; t++) begin
      @(negedge clk_i);
      if (valid_o && ready_i && last_o) begin
        seen = 1'b1;
        break;
      end
    end
    check("t3_first_drain_seen", seen, 1'b1);
    @(negedge clk_i);
    check("t3_ready_after_drain", ready_o, 1'b1);
    wait_drain();

    // Framing error: last_i is early on j=9 and missing on j=15.
    set_ready(1);
    err0 = err_cnt;
    for (int j = 0; j < N; j++) send(DW'($urandom), j == 9, 1'b0);
    wait_drain();
    check("t4_err_pulses", err_cnt - err0, 2);

    // Reset while frame 1 drains and frame 2 is partially written.
    set_ready(0);
    for (int j = 0; j < N; j++) send(DW'($urandom), j == N - 1, 1'b0);
    rdy_mode = 1;
    for (int j = 0; j < 7; j++) send(DW'($urandom), 1'b0, 1'b0);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("t5_valid_in_reset", valid_o, 1'b0);
    check("t5_ready_in_reset", ready_o, 1'b1);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    out0 = out_cnt;
    for (int j = 0; j < N; j++) send(DW'(rev_k(j)), j == N - 1, 1'b0);
    wait_drain();
    check("t5_clean_frame_count", out_cnt - out0, N);

    // Random valid_i/ready_i at 50% over 20 frames.
    set_ready(2);
    out0 = out_cnt;
    for (int f = 0; f < 20; f++)
      for (int j = 0; j < N; j++) send(DW'($urandom), j == N - 1, 1'b1);
    wait_drain();
    check("t6_out_count", out_cnt - out0, 20 * N);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
